// File: rtl/culsans_tohost_monitor_pkg.sv
// Shared constants and types for the tohost exit-code snooper.
package culsans_tohost_monitor_pkg;

    localparam logic [63:0] DRAM_BASE     = 64'h8000_0000;
    localparam logic [63:0] TOHOST_OFFSET = 64'h1000;

    typedef logic [31:0] exit_t;

endpackage

// File: rtl/culsans_tohost_monitor_fifo.sv
// Small pointer-based FIFO for tracking AW bursts.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module culsans_tohost_monitor_fifo #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic [PtrW-1:0]                  rd_q, wr_q;
    logic [PtrW:0]                    cnt_q;
    logic                             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PtrW+1)'(DEPTH));
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + PtrW'(1);
            end
            if (do_pop) rd_q <= rd_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PtrW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PtrW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/culsans_tohost_monitor.sv
// Passive AXI write snooper: captures the first odd value written to tohost
// as a sticky exit code. Never drives or stalls the bus.
module culsans_tohost_monitor
    import culsans_tohost_monitor_pkg::*;
#(
    parameter int unsigned          AddrWidth      = 64,
    parameter int unsigned          DataWidth      = 64,
    parameter logic [AddrWidth-1:0] ToHostAddr     = AddrWidth'(DRAM_BASE + TOHOST_OFFSET),
    parameter int unsigned          MaxOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   aw_valid_i,
    input  logic                   aw_ready_i,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic [7:0]             aw_len_i,
    input  logic                   w_valid_i,
    input  logic                   w_ready_i,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_last_i,
    output logic [31:0]            exit_o,
    output logic                   protocol_err_o
);

    localparam int unsigned          ByteOffW = $clog2(DataWidth/8);
    localparam int unsigned          NumLanes = DataWidth/32;
    localparam logic [AddrWidth-1:0] LaneSel  = (ToHostAddr >> 2) & AddrWidth'(NumLanes-1);
    localparam int unsigned          LaneIdx  = 32'(LaneSel);

    logic        aw_hs, w_hs, aw_hit;
    logic        fifo_empty, fifo_full, fifo_head;
    logic        have_head, head_hit, bypass, push, pop, overflow, orphan;
    logic [31:0] cand_word;
    logic [3:0]  cand_strb;
    logic        capture;
    logic [7:0]  beat_q;
    logic        cap_dis_q, err_q;
    exit_t       exit_q;
    logic        unused_inputs;

    // Burst length is implied by w_last; only lane bytes of the data are relevant.
    assign unused_inputs = ^{aw_len_i, w_data_i, w_strb_i};

    assign aw_hs  = aw_valid_i && aw_ready_i;
    assign w_hs   = w_valid_i && w_ready_i;
    assign aw_hit = (aw_addr_i >> ByteOffW) == (ToHostAddr >> ByteOffW);

    // With nothing queued, a same-cycle AW supplies the burst for this beat.
    assign bypass    = w_hs && aw_hs && fifo_empty;
    assign have_head = w_hs && (!fifo_empty || aw_hs);
    assign head_hit  = fifo_empty ? aw_hit : fifo_head;
    assign orphan    = w_hs && fifo_empty && !aw_hs;
    assign pop       = w_hs && w_last_i && !fifo_empty;
    assign push      = aw_hs && !(bypass && w_last_i);
    assign overflow  = push && fifo_full && !pop;

    culsans_tohost_monitor_fifo #(
        .DATA_WIDTH (1),
        .DEPTH      (MaxOutstanding)
    ) i_aw_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .push_i  (push),
        .data_i  (aw_hit),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cand_word = w_data_i[LaneIdx*32 +: 32];
    assign cand_strb = w_strb_i[LaneIdx*4 +: 4];

    // Even values are HTIF syscall pointers, not exit codes.
    assign capture = have_head && head_hit && (beat_q == 8'd0) && !cap_dis_q &&
                     (&cand_strb) && cand_word[0] && !exit_q[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q    <= '0;
            cap_dis_q <= 1'b0;
            err_q     <= 1'b0;
            exit_q    <= '0;
        end else begin
            if (have_head) beat_q <= w_last_i ? 8'd0 : beat_q + 8'd1;
            if (overflow) begin
                err_q     <= 1'b1;
                cap_dis_q <= 1'b1;
            end
            if (orphan)  err_q  <= 1'b1;
            if (capture) exit_q <= cand_word;
        end
    end

    assign exit_o         = exit_q;
    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_culsans_tohost_monitor.sv
// Directed and randomized checks of the tohost monitor against a burst-level model.
module tb_culsans_tohost_monitor;

    localparam logic [63:0] TOHOST = 64'h8000_1000;
    localparam logic [63:0] OTHER  = 64'h8000_2000;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aw_valid = 1'b0, aw_ready = 1'b0;
    logic [63:0] aw_addr = '0;
    logic [7:0]  aw_len = '0;
    logic        w_valid = 1'b0, w_ready = 1'b0;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        w_last = 1'b0;
    logic [31:0] exit_o;
    logic        protocol_err_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue of outstanding bursts (hit flag) and current beat index.
    bit          mq[$];
    int          m_beat;
    bit          m_dis, m_err;
    logic [31:0] m_exit;

    // Generator bookkeeping: beats still owed per accepted AW.
    int          gen_q[$];

    culsans_tohost_monitor dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .aw_valid_i     (aw_valid),
        .aw_ready_i     (aw_ready),
        .aw_addr_i      (aw_addr),
        .aw_len_i       (aw_len),
        .w_valid_i      (w_valid),
        .w_ready_i      (w_ready),
        .w_data_i       (w_data),
        .w_strb_i       (w_strb),
        .w_last_i       (w_last),
        .exit_o         (exit_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_beat = 0;
        m_dis  = 0;
        m_err  = 0;
        m_exit = '0;
    endtask

    // Advance the model by the handshakes on the bus this cycle.
    task automatic model_step();
        bit awh, wh, hit, head, have, byp;
        awh = aw_valid && aw_ready;
        wh  = w_valid && w_ready;
        hit = (aw_addr[63:3] == TOHOST[63:3]);
        byp = wh && awh && (mq.size() == 0);
        if (wh) begin
            have = 1;
            if (mq.size() > 0) head = mq[0];
            else if (awh)      head = hit;
            else begin
                have = 0;
                head = 0;
                m_err = 1;
            end
            if (have) begin
                if (head && m_beat == 0 && !m_dis && w_strb[3:0] == 4'hF &&
                    w_data[0] && !m_exit[0])
                    m_exit = w_data[31:0];
                if (w_last) begin
                    if (mq.size() > 0) void'(mq.pop_front());
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
        end
        if (awh && !(byp && w_last)) begin
            if (mq.size() < DEPTH) mq.push_back(hit);
            else begin
                m_err = 1;
                m_dis = 1;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("exit_vs_model", exit_o, m_exit);
        chk("err_vs_model", {31'b0, protocol_err_o}, {31'b0, m_err});
    endtask

    task automatic drive(input bit awv, input logic [63:0] a, input logic [7:0] l,
                         input bit wv, input logic [63:0] d, input logic [7:0] s, input bit wl);
        aw_valid = awv; aw_ready = 1'b1; aw_addr = a; aw_len = l;
        w_valid = wv; w_ready = 1'b1; w_data = d; w_strb = s; w_last = wl;
        cycle();
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        w_last   = 1'b0;
    endtask

    task automatic do_reset();
        aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0;
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_exit", exit_o, 32'h0);
        chk("rst_err", {31'b0, protocol_err_o}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic tohost_write(input logic [63:0] d);
        drive(1, TOHOST, 8'd0, 0, '0, 8'h00, 0);
        drive(0, '0, 8'd0, 1, d, 8'hFF, 1);
    endtask

    initial begin
        model_clear();
        #12;
        do_reset();

        // Basic exit write, one-cycle latency after the W handshake
        drive(1, TOHOST, 8'd0, 0, '0, 8'h00, 0);
        chk("t1_pre", exit_o, 32'h0);
        drive(0, '0, 8'd0, 1, 64'h1, 8'hFF, 1);
        chk("t1_exit", exit_o, 32'h1);
        chk("t1_err", {31'b0, protocol_err_o}, 32'h0);

        // Sticky first exit
        do_reset();
        tohost_write(64'h2B);
        chk("t2_exit", exit_o, 32'h2B);
        tohost_write(64'h1);
        chk("t2_sticky", exit_o, 32'h2B);

        // Non-tohost writes and even (syscall) values are ignored
        do_reset();
        drive(1, OTHER, 8'd0, 0, '0, 8'h00, 0);
        drive(0, '0, 8'd0, 1, 64'h1, 8'hFF, 1);
        chk("t3_other", exit_o, 32'h0);
        tohost_write(64'h8000_3000);
        chk("t3_even", exit_o, 32'h0);
        tohost_write(64'h5);
        chk("t3_exit", exit_o, 32'h5);

        // FIFO overflow disables capture
        do_reset();
        repeat (4) drive(1, OTHER, 8'd3, 0, '0, 8'h00, 0);
        chk("t4_full_noerr", {31'b0, protocol_err_o}, 32'h0);
        drive(1, OTHER, 8'd3, 0, '0, 8'h00, 0);
        chk("t4_ovf_err", {31'b0, protocol_err_o}, 32'h1);
        tohost_write(64'h1);
        chk("t4_exit", exit_o, 32'h0);

        // W with no AW
        do_reset();
        drive(0, '0, 8'd0, 1, 64'h1, 8'hFF, 1);
        chk("t5_orphan_err", {31'b0, protocol_err_o}, 32'h1);
        chk("t5_orphan_exit", exit_o, 32'h0);

        // Partial strobes ignored, same-cycle bypass captures
        do_reset();
        drive(1, TOHOST, 8'd0, 1, 64'h9, 8'hF0, 1);
        chk("t5_partial", exit_o, 32'h0);
        drive(1, TOHOST, 8'd0, 1, 64'h7, 8'hFF, 1);
        chk("t5_bypass", exit_o, 32'h7);
        chk("t5_err", {31'b0, protocol_err_o}, 32'h0);
        drive(1, TOHOST, 8'd0, 1, 64'h3, 8'hF0, 1);
        chk("t5_after", exit_o, 32'h7);

        // Async reset in the middle of a burst
        do_reset();
        drive(1, TOHOST, 8'd3, 0, '0, 8'h00, 0);
        drive(0, '0, 8'd0, 1, 64'h2, 8'hFF, 0);
        drive(0, '0, 8'd0, 1, 64'h11, 8'hFF, 0);
        chk("t6_beat1", exit_o, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_exit", exit_o, 32'h0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tohost_write(64'h3);
        chk("t6_exit", exit_o, 32'h3);
        chk("t6_err", {31'b0, protocol_err_o}, 32'h0);

        // Randomized legal traffic with ready backpressure
        for (int r = 0; r < 8; r++) begin
            do_reset();
            gen_q.delete();
            for (int c = 0; c < 80; c++) begin
                bit awh, wh, byp;
                aw_ready = $urandom_range(0, 1);
                w_ready  = ($urandom_range(0, 3) != 0);
                aw_valid = (gen_q.size() < 3) && ($urandom_range(0, 1) == 1);
                case ($urandom_range(0, 3))
                    0:       aw_addr = TOHOST;
                    1:       aw_addr = TOHOST + 64'h4;
                    2:       aw_addr = TOHOST + 64'h8;
                    default: aw_addr = OTHER;
                endcase
                aw_len = 8'($urandom_range(0, 2));
                w_data = {$urandom, $urandom};
                w_data[0] = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 3))
                    0:       w_strb = 8'h0F;
                    1:       w_strb = 8'hF0;
                    2:       w_strb = 8'h07;
                    default: w_strb = 8'hFF;
                endcase
                if (gen_q.size() > 0) begin
                    w_valid = $urandom_range(0, 1);
                    w_last  = (gen_q[0] == 1);
                end else if (aw_valid && aw_ready) begin
                    w_valid = $urandom_range(0, 1);
                    w_last  = (aw_len == 0);
                end else begin
                    w_valid = 1'b0;
                    w_last  = 1'b0;
                end
                awh = aw_valid && aw_ready;
                wh  = w_valid && w_ready;
                byp = wh && awh && (gen_q.size() == 0);
                cycle();
                if (wh && !byp) begin
                    gen_q[0] = gen_q[0] - 1;
                    if (gen_q[0] == 0) void'(gen_q.pop_front());
                end
                if (byp) begin
                    if (int'(aw_len) > 0) gen_q.push_back(int'(aw_len));
                end else if (awh) begin
                    gen_q.push_back(int'(aw_len) + 1);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
